vga_vram_arbiter: RTL
=====================

# vga_vram_arbiter

Single-port VRAM arbiter that shares one 32-bit synchronous-read VRAM between the Avalon-MM slave (NIOS text/palette writes and readback) and the VGA text display fetch path. It sits between the Avalon interface and the VRAM macro, with the display fetcher as a second requester. The display has deadline priority. A bounded-starvation rule guarantees forward progress for the CPU. The block returns read data to the owning requester one cycle after issue.

## Interface
- ADDR_W, 11, word address width of both requesters and the RAM
- VRAM_WORDS, 601, number of implemented words; addresses at or above this are out of range
- STARVE_LIMIT, 4, consecutive CPU denials before the CPU is given one priority slot (legal range 1..15)
- CLK  in  1  system clock, 50 MHz, also the VGA clock
- RESET  in  1  synchronous, active-low reset
- AVL_CS, AVL_READ, AVL_WRITE  in  1 each  Avalon-MM request qualifiers
- AVL_BYTE_EN  in  4  byte enables for writes
- AVL_ADDR  in  ADDR_W  word address
- AVL_WRITEDATA  in  32  write data
- AVL_WAITREQUEST  out  1  high = request not accepted this cycle
- AVL_READDATA  out  32  read data
- AVL_READDATAVALID  out  1  one-cycle strobe qualifying AVL_READDATA
- DISP_REQ  in  1  display fetch request, held until granted
- DISP_ADDR  in  ADDR_W  display word address, stable while DISP_REQ is high
- DISP_GNT  out  1  display request issued this cycle
- DISP_VALID  out  1  one-cycle strobe qualifying DISP_DATA
- DISP_DATA  out  32  display read data
- RAM_ADDR  out  ADDR_W  VRAM address
- RAM_WDATA  out  32  VRAM write data
- RAM_BYTEEN  out  4  VRAM byte enables
- RAM_WREN, RAM_RDEN  out  1 each  VRAM strobes
- RAM_Q  in  32  VRAM read data, valid the cycle after RAM_RDEN
- STAT_DISP_LATE  out  16  statistics counter (see Configuration)
- STAT_CPU_WAIT  out  16  statistics counter (see Configuration)

## Operation
- The CPU request is cpu_req = AVL_CS & (AVL_READ | AVL_WRITE). If AVL_READ and AVL_WRITE are both high, the access is a write and the read is ignored.
- Arbitration is combinational each cycle and works in two modes.
  - DISP_PRIO (default): DISP_REQ wins if asserted; otherwise cpu_req wins.
  - CPU_PRIO: cpu_req wins if asserted; otherwise DISP_REQ wins.
- Starvation counter `starve` is 4 bits.
  - Increments in any cycle where cpu_req is high and the CPU is denied.
  - Clears in any cycle where the CPU is granted.
- The mode is CPU_PRIO exactly when starve == STARVE_LIMIT; otherwise it is DISP_PRIO.
- Granted display access: RAM_ADDR=DISP_ADDR, RAM_RDEN=1, DISP_GNT=1.
- Granted CPU write: RAM_ADDR=AVL_ADDR, RAM_WDATA=AVL_WRITEDATA, RAM_BYTEEN=AVL_BYTE_EN, RAM_WREN=1.
- Granted CPU read: RAM_ADDR=AVL_ADDR, RAM_RDEN=1.
- Out-of-range CPU access (AVL_ADDR ≥ VRAM_WORDS):
  - Accepted without a RAM cycle and without consuming a slot, so the display may be granted in the same cycle.
  - A write is dropped.
  - A read returns 0.
  - `starve` clears.
- AVL_WAITREQUEST = cpu_req & ~cpu_grant. It is 0 when there is no request.
- Return tag register (2 bits: none/DISP/CPU/CPU_ZERO) records the owner of each issued read.
  - Next cycle, the owner's VALID strobe is driven, with its data = RAM_Q (or 0 for CPU_ZERO).
  - The non-owner's data output holds its last value.
- A write never produces AVL_READDATAVALID.

## Timing
- Issue to data latency is exactly 1 cycle for both requesters. Back-to-back issue is allowed every cycle.
- Worst-case DISP_GNT delay after DISP_REQ rises is 1 cycle (one CPU_PRIO slot). A display fetcher budgeting 32 CLK per word always meets its deadline.
- Worst-case CPU wait under continuous DISP_REQ is STARVE_LIMIT cycles.
- With RESET low at a clock edge:
  - `starve`=0 and tag=none.
  - AVL_READDATAVALID=0 and DISP_VALID=0.
  - AVL_READDATA=0, DISP_DATA=0, stats=0.
- While RESET is low: RAM_WREN=RAM_RDEN=0, DISP_GNT=0, AVL_WAITREQUEST=1 (requests stall).
- Reset asserted while a read is in flight: the return strobe is suppressed.
- Reset releases into DISP_PRIO.

## Configuration
- VRAM_ARB_STATS_EN defined:
  - STAT_DISP_LATE counts cycles with DISP_REQ=1 & DISP_GNT=0.
  - STAT_CPU_WAIT counts cycles with AVL_WAITREQUEST=1 & cpu_req=1.
  - Both are 16-bit, saturate at 0xFFFF, and clear on reset.
- VRAM_ARB_STATS_EN undefined: both ports are tied to 0 and no counter logic is built.

## Test plan
- CPU write 0xDEADBEEF to addr 5 with BYTE_EN=4'b0101, then read addr 5 with no display traffic.
  - Required: WAITREQUEST=0 both cycles.
  - Required: READDATAVALID 1 cycle after the read, data = 0x00AD00EF over a prior 0.
- DISP_REQ and CPU read asserted together at cycle 0 with STARVE_LIMIT=4.
  - Required: DISP_GNT at cycle 0 and DISP_VALID at cycle 1.
  - Required: CPU granted at cycle 1, READDATAVALID at cycle 2.
- DISP_REQ held continuously with a CPU write pending.
  - Required: WAITREQUEST high 4 cycles, CPU granted on cycle 4, DISP_GNT=0 on cycle 4 only.
  - Required (STATS_EN): STAT_CPU_WAIT=4 and STAT_DISP_LATE=1.
- CPU read at addr 700 concurrent with DISP_REQ.
  - Required: both accepted in the same cycle, READDATAVALID with 0 next cycle, RAM_RDEN only for the display.
- RESET low for 1 cycle while a CPU read is in flight.
  - Required: no READDATAVALID.
  - Required: WAITREQUEST=1 during reset, and `starve` and stats read 0 afterwards.

Source files
------------

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: Avalon-MM CPU port vs. VGA display fetch, display first,
// with a starvation slot for the CPU. Optional statistics counters: `VRAM_ARB_STATS_EN.
module vga_vram_arbiter #(
   parameter int ADDR_W       = 11,
   parameter int VRAM_WORDS   = 601,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_avl_cs,
   input  logic              i_avl_read,
   input  logic              i_avl_write,
   input  logic [3:0]        i_avl_byte_en,
   input  logic [ADDR_W-1:0] i_avl_addr,
   input  logic [31:0]       i_avl_writedata,
   output logic              o_avl_waitrequest,
   output logic [31:0]       o_avl_readdata,
   output logic              o_avl_readdatavalid,
   input  logic              i_disp_req,
   input  logic [ADDR_W-1:0] i_disp_addr,
   output logic              o_disp_gnt,
   output logic              o_disp_valid,
   output logic [31:0]       o_disp_data,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [31:0]       o_ram_wdata,
   output logic [3:0]        o_ram_byteen,
   output logic              o_ram_wren,
   output logic              o_ram_rden,
   input  logic [31:0]       i_ram_q,
   output logic [15:0]       o_stat_disp_late,
   output logic [15:0]       o_stat_cpu_wait
);

   typedef enum logic [1:0] {
      TAG_NONE     = 2'd0,
      TAG_DISP     = 2'd1,
      TAG_CPU      = 2'd2,
      TAG_CPU_ZERO = 2'd3
   } tag_t;

   localparam logic [ADDR_W:0] C_WORDS = (ADDR_W+1)'(VRAM_WORDS);
   localparam logic [3:0]      C_LIMIT = 4'(STARVE_LIMIT);

   logic        w_cpu_req;
   logic        w_cpu_wr;
   logic        w_cpu_rd;
   logic        w_oor;
   logic        w_cpu_prio;
   logic        w_cpu_gnt;
   logic        w_disp_gnt;
   logic        w_cpu_rd_gnt;
   logic [3:0]  w_starve_nxt;
   tag_t        w_tag_nxt;
   logic        w_zero_nxt;
   logic        w_avl_valid;
   logic        w_disp_valid;
   logic [31:0] w_avl_rdata;

   logic [3:0]  r_starve;
   tag_t        r_tag;
   logic        r_zero_rd;
   logic [31:0] r_avl_data;
   logic [31:0] r_disp_data;

   assign w_cpu_req    = i_avl_cs & (i_avl_read | i_avl_write);
   assign w_cpu_wr     = i_avl_write;
   assign w_cpu_rd     = i_avl_read & ~i_avl_write;
   assign w_oor        = {1'b0, i_avl_addr} >= C_WORDS;
   assign w_cpu_prio   = (r_starve == C_LIMIT);
   assign w_cpu_rd_gnt = w_cpu_gnt & w_cpu_rd;

   // Grant selection; out-of-range CPU accesses never touch the RAM so they coexist with display.
   always_comb begin
      w_cpu_gnt  = 1'b0;
      w_disp_gnt = 1'b0;
      if (!i_reset_n) begin
         w_cpu_gnt  = 1'b0;
         w_disp_gnt = 1'b0;
      end else if (w_cpu_req & w_oor) begin
         w_cpu_gnt  = 1'b1;
         w_disp_gnt = i_disp_req;
      end else if (w_cpu_prio) begin
         w_cpu_gnt  = w_cpu_req;
         w_disp_gnt = i_disp_req & ~w_cpu_req;
      end else begin
         w_disp_gnt = i_disp_req;
         w_cpu_gnt  = w_cpu_req & ~i_disp_req;
      end
   end

   // RAM port steering from the winning requester.
   always_comb begin
      o_ram_addr   = '0;
      o_ram_wdata  = 32'h0;
      o_ram_byteen = 4'h0;
      o_ram_wren   = 1'b0;
      o_ram_rden   = 1'b0;
      if (w_disp_gnt) begin
         o_ram_addr = i_disp_addr;
         o_ram_rden = 1'b1;
      end else if (w_cpu_gnt & ~w_oor) begin
         o_ram_addr = i_avl_addr;
         if (w_cpu_wr) begin
            o_ram_wdata  = i_avl_writedata;
            o_ram_byteen = i_avl_byte_en;
            o_ram_wren   = 1'b1;
         end else begin
            o_ram_rden = 1'b1;
         end
      end else begin
         o_ram_addr = '0;
      end
   end

   // Next starvation count and return tag for the read issued this cycle.
   always_comb begin
      w_starve_nxt = r_starve;
      w_tag_nxt    = TAG_NONE;
      w_zero_nxt   = 1'b0;
      if (w_cpu_gnt) begin
         w_starve_nxt = 4'd0;
      end else if (w_cpu_req) begin
         w_starve_nxt = r_starve + 4'd1;
      end else begin
         w_starve_nxt = r_starve;
      end
      if (w_disp_gnt) begin
         w_tag_nxt  = TAG_DISP;
         w_zero_nxt = w_cpu_rd_gnt;
      end else if (w_cpu_rd_gnt & w_oor) begin
         w_tag_nxt = TAG_CPU_ZERO;
      end else if (w_cpu_rd_gnt) begin
         w_tag_nxt = TAG_CPU;
      end else begin
         w_tag_nxt = TAG_NONE;
      end
   end

   assign w_avl_valid  = i_reset_n & ((r_tag == TAG_CPU) | (r_tag == TAG_CPU_ZERO) | r_zero_rd);
   assign w_disp_valid = i_reset_n & (r_tag == TAG_DISP);
   assign w_avl_rdata  = (r_tag == TAG_CPU) ? i_ram_q : 32'h0;

   // Arbiter state and held read data; a zero-return rides beside a display read in r_zero_rd.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_starve    <= 4'd0;
         r_tag       <= TAG_NONE;
         r_zero_rd   <= 1'b0;
         r_avl_data  <= 32'h0;
         r_disp_data <= 32'h0;
      end else begin
         r_starve  <= w_starve_nxt;
         r_tag     <= w_tag_nxt;
         r_zero_rd <= w_zero_nxt;
         if (w_avl_valid) begin
            r_avl_data <= w_avl_rdata;
         end
         if (w_disp_valid) begin
            r_disp_data <= i_ram_q;
         end
      end
   end

   assign o_avl_waitrequest   = ~i_reset_n | (w_cpu_req & ~w_cpu_gnt);
   assign o_avl_readdatavalid = w_avl_valid;
   assign o_avl_readdata      = w_avl_valid ? w_avl_rdata : r_avl_data;
   assign o_disp_gnt          = w_disp_gnt;
   assign o_disp_valid        = w_disp_valid;
   assign o_disp_data         = w_disp_valid ? i_ram_q : r_disp_data;

`ifdef VRAM_ARB_STATS_EN
   logic [15:0] r_stat_disp_late;
   logic [15:0] r_stat_cpu_wait;

   // Saturating counters for display lateness and CPU stall cycles.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_stat_disp_late <= 16'h0;
         r_stat_cpu_wait  <= 16'h0;
      end else begin
         if (i_disp_req & ~w_disp_gnt & (r_stat_disp_late != 16'hFFFF)) begin
            r_stat_disp_late <= r_stat_disp_late + 16'd1;
         end
         if (o_avl_waitrequest & w_cpu_req & (r_stat_cpu_wait != 16'hFFFF)) begin
            r_stat_cpu_wait <= r_stat_cpu_wait + 16'd1;
         end
      end
   end

   assign o_stat_disp_late = r_stat_disp_late;
   assign o_stat_cpu_wait  = r_stat_cpu_wait;
`else
   assign o_stat_disp_late = 16'h0;
   assign o_stat_cpu_wait  = 16'h0;
`endif

endmodule
